// File: rtl/atm_pkg.sv
// atm_pkg
// Shared definitions for the ATM session controller:
//   - state_e      : controller state encoding (visible on the 'state' port)
//   - STAT_*       : result codes reported on 'status' alongside 'done'
//   - MODE_*       : operation select codes sampled in MENU
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MENU     = 3'd1,
    ST_WITHDRAW = 3'd2,
    ST_DEPOSIT  = 3'd3,
    ST_TRANSFER = 3'd4
  } state_e;

  localparam logic [2:0] STAT_OK       = 3'd0;
  localparam logic [2:0] STAT_BAD_PIN  = 3'd1;
  localparam logic [2:0] STAT_LOCKED   = 3'd2;
  localparam logic [2:0] STAT_INSUFF   = 3'd3;
  localparam logic [2:0] STAT_BAD_TGT  = 3'd4;
  localparam logic [2:0] STAT_OVERFLOW = 3'd5;
  localparam logic [2:0] STAT_ZERO_AMT = 3'd6;
  localparam logic [2:0] STAT_TIMEOUT  = 3'd7;

  localparam logic [1:0] MODE_BALANCE  = 2'b00;
  localparam logic [1:0] MODE_WITHDRAW = 2'b01;
  localparam logic [1:0] MODE_DEPOSIT  = 2'b10;
  localparam logic [1:0] MODE_TRANSFER = 2'b11;

endpackage

// File: rtl/atm_acct_table.sv
// atm_acct_table
// Account record storage for the ATM controller.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   cfg_*                : record programming (write sets valid, clears tries/lock)
//   lk_acc, lk_pin       : lookup key; lk_hit/lk_idx give the lowest matching valid
//                          record, lk_pin_ok/lk_locked/lk_bal describe that record
//   rd_idx, rd_bal       : balance read of the session record
//   try_fail, try_clr    : bump or clear the PIN retry counter of the looked-up record
//   wa_*, wb_*           : two balance write ports (source and target of a transfer)
//   locked               : per-record lockout flags
module atm_acct_table
  import atm_pkg::*;
#(
  parameter int NUM_ACC   = 4,
  parameter int ACC_W     = 4,
  parameter int PIN_W     = 8,
  parameter int BAL_W     = 8,
  parameter int MAX_TRIES = 3,
  parameter int IDX_W     = $clog2(NUM_ACC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [ACC_W-1:0]   cfg_acc,
  input  logic [PIN_W-1:0]   cfg_pin,
  input  logic [BAL_W-1:0]   cfg_bal,
  input  logic [ACC_W-1:0]   lk_acc,
  input  logic [PIN_W-1:0]   lk_pin,
  output logic               lk_hit,
  output logic [IDX_W-1:0]   lk_idx,
  output logic               lk_pin_ok,
  output logic               lk_locked,
  output logic [BAL_W-1:0]   lk_bal,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BAL_W-1:0]   rd_bal,
  input  logic               try_fail,
  input  logic               try_clr,
  input  logic               wa_en,
  input  logic [IDX_W-1:0]   wa_idx,
  input  logic [BAL_W-1:0]   wa_bal,
  input  logic               wb_en,
  input  logic [IDX_W-1:0]   wb_idx,
  input  logic [BAL_W-1:0]   wb_bal,
  output logic [NUM_ACC-1:0] locked
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [NUM_ACC-1:0] valid_q, valid_d;
  logic [NUM_ACC-1:0] lock_q, lock_d;
  logic [ACC_W-1:0]   acc_q [NUM_ACC];
  logic [ACC_W-1:0]   acc_d [NUM_ACC];
  logic [PIN_W-1:0]   pin_q [NUM_ACC];
  logic [PIN_W-1:0]   pin_d [NUM_ACC];
  logic [BAL_W-1:0]   bal_q [NUM_ACC];
  logic [BAL_W-1:0]   bal_d [NUM_ACC];
  logic [TRY_W-1:0]   tries_q [NUM_ACC];
  logic [TRY_W-1:0]   tries_d [NUM_ACC];
  logic [TRY_W-1:0]   next_try;

  // Priority lookup: scanning from the top index down lets the lowest
  // matching index overwrite the result, so duplicate IDs resolve to it.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = NUM_ACC - 1; i >= 0; i--) begin
      if (valid_q[i] && (acc_q[i] == lk_acc)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  assign lk_pin_ok = (pin_q[lk_idx] == lk_pin);
  assign lk_locked = lock_q[lk_idx];
  assign lk_bal    = bal_q[lk_idx];
  assign rd_bal    = bal_q[rd_idx];
  assign locked    = lock_q;

  // Next-state of the table. Programming is exclusive with session traffic
  // (the controller only allows it in IDLE), but it is given priority anyway.
  always_comb begin
    valid_d  = valid_q;
    lock_d   = lock_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    bal_d    = bal_q;
    tries_d  = tries_q;
    next_try = tries_q[lk_idx] + TRY_W'(1);
    if (cfg_we) begin
      valid_d[cfg_idx] = 1'b1;
      lock_d[cfg_idx]  = 1'b0;
      acc_d[cfg_idx]   = cfg_acc;
      pin_d[cfg_idx]   = cfg_pin;
      bal_d[cfg_idx]   = cfg_bal;
      tries_d[cfg_idx] = '0;
    end else begin
      // Locked records never reach try_fail, so the counter cannot pass MAX_TRIES.
      if (try_fail) begin
        tries_d[lk_idx] = next_try;
        if (next_try >= TRY_W'(MAX_TRIES)) begin
          lock_d[lk_idx] = 1'b1;
        end
      end
      if (try_clr) begin
        tries_d[lk_idx] = '0;
      end
      if (wa_en) begin
        bal_d[wa_idx] = wa_bal;
      end
      if (wb_en) begin
        bal_d[wb_idx] = wb_bal;
      end
    end
  end

  // Record registers; reset wins over any pending update in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i]   <= '0;
        pin_q[i]   <= '0;
        bal_q[i]   <= '0;
        tries_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      lock_q  <= lock_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      bal_q   <= bal_d;
      tries_q <= tries_d;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
// Session controller for the ATM: login with PIN-retry lockout, then balance,
// withdraw, deposit and transfer operations, with an inactivity timeout.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   mode           : operation select, sampled on load in MENU
//   keypad         : {acc, pin} for login, {tgt_acc, amount} for operations
//   load           : one-cycle strobe qualifying keypad/mode
//   logout         : end the session (beats load)
//   cfg_*          : account table programming, honoured only in IDLE
//   state, auth    : current state and session-active flag
//   bal            : last reported balance of the session account
//   status, done   : result code and its one-cycle valid pulse
//   locked         : per-record lockout flags
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACC     = 4,
  parameter int ACC_W       = 4,
  parameter int PIN_W       = 8,
  parameter int BAL_W       = 8,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int IDX_W       = $clog2(NUM_ACC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [ACC_W+PIN_W-1:0] keypad,
  input  logic                   load,
  input  logic                   logout,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [ACC_W-1:0]       cfg_acc,
  input  logic [PIN_W-1:0]       cfg_pin,
  input  logic [BAL_W-1:0]       cfg_bal,
  output logic [2:0]             state,
  output logic                   auth,
  output logic [BAL_W-1:0]       bal,
  output logic [2:0]             status,
  output logic                   done,
  output logic [NUM_ACC-1:0]     locked
);

  localparam int KP_W  = ACC_W + PIN_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sess_idx_q, sess_idx_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [2:0]       status_q, status_d;
  logic             done_q, done_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [ACC_W-1:0] kp_acc;
  logic [PIN_W-1:0] kp_pin;
  logic [BAL_W-1:0] kp_amt;

  logic             lk_hit, lk_pin_ok, lk_locked;
  logic [IDX_W-1:0] lk_idx;
  logic [BAL_W-1:0] lk_bal, rd_bal;
  logic             tbl_cfg_we, try_fail, try_clr, wa_en, wb_en;
  logic [BAL_W-1:0] wa_bal, wb_bal;

  logic [BAL_W-1:0] wd_bal;
  logic [BAL_W:0]   dep_sum, tgt_sum;
  logic             amt_zero, amt_insuff;

  assign kp_acc = keypad[KP_W-1:PIN_W];
  assign kp_pin = keypad[PIN_W-1:0];
  assign kp_amt = keypad[BAL_W-1:0];

  // The same lookup serves both login (acc field) and transfer target (tgt field).
  atm_acct_table #(
    .NUM_ACC   (NUM_ACC),
    .ACC_W     (ACC_W),
    .PIN_W     (PIN_W),
    .BAL_W     (BAL_W),
    .MAX_TRIES (MAX_TRIES),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (tbl_cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_acc   (cfg_acc),
    .cfg_pin   (cfg_pin),
    .cfg_bal   (cfg_bal),
    .lk_acc    (kp_acc),
    .lk_pin    (kp_pin),
    .lk_hit    (lk_hit),
    .lk_idx    (lk_idx),
    .lk_pin_ok (lk_pin_ok),
    .lk_locked (lk_locked),
    .lk_bal    (lk_bal),
    .rd_idx    (sess_idx_q),
    .rd_bal    (rd_bal),
    .try_fail  (try_fail),
    .try_clr   (try_clr),
    .wa_en     (wa_en),
    .wa_idx    (sess_idx_q),
    .wa_bal    (wa_bal),
    .wb_en     (wb_en),
    .wb_idx    (lk_idx),
    .wb_bal    (wb_bal),
    .locked    (locked)
  );

  // Sums are one bit wider so the carry out flags a balance overflow.
  assign wd_bal     = rd_bal - kp_amt;
  assign dep_sum    = {1'b0, rd_bal} + {1'b0, kp_amt};
  assign tgt_sum    = {1'b0, lk_bal} + {1'b0, kp_amt};
  assign amt_zero   = (kp_amt == '0);
  assign amt_insuff = (kp_amt > rd_bal);

  // Next-state and result logic. Priority in a session: logout, then load,
  // then timeout (a load restarts the idle timer, so it cannot time out).
  always_comb begin
    state_d    = state_q;
    sess_idx_d = sess_idx_q;
    bal_d      = bal_q;
    status_d   = status_q;
    done_d     = 1'b0;
    tbl_cfg_we = 1'b0;
    try_fail   = 1'b0;
    try_clr    = 1'b0;
    wa_en      = 1'b0;
    wa_bal     = wd_bal;
    wb_en      = 1'b0;
    wb_bal     = tgt_sum[BAL_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          tbl_cfg_we = 1'b1;
        end else if (load) begin
          done_d = 1'b1;
          if (!lk_hit) begin
            status_d = STAT_BAD_PIN;
          end else if (lk_locked) begin
            status_d = STAT_LOCKED;
          end else if (!lk_pin_ok) begin
            try_fail = 1'b1;
            status_d = STAT_BAD_PIN;
          end else begin
            try_clr    = 1'b1;
            sess_idx_d = lk_idx;
            state_d    = ST_MENU;
            status_d   = STAT_OK;
          end
        end
      end
      default: begin
        if (logout) begin
          state_d = ST_IDLE;
        end else if (load) begin
          state_d = ST_MENU;
          case (state_q)
            ST_MENU: begin
              case (mode)
                MODE_BALANCE: begin
                  bal_d    = rd_bal;
                  status_d = STAT_OK;
                  done_d   = 1'b1;
                end
                MODE_WITHDRAW: state_d = ST_WITHDRAW;
                MODE_DEPOSIT:  state_d = ST_DEPOSIT;
                default:       state_d = ST_TRANSFER;
              endcase
            end
            ST_WITHDRAW: begin
              done_d = 1'b1;
              if (amt_zero) begin
                status_d = STAT_ZERO_AMT;
              end else if (amt_insuff) begin
                status_d = STAT_INSUFF;
              end else begin
                wa_en    = 1'b1;
                bal_d    = wd_bal;
                status_d = STAT_OK;
              end
            end
            ST_DEPOSIT: begin
              done_d = 1'b1;
              if (amt_zero) begin
                status_d = STAT_ZERO_AMT;
              end else if (dep_sum[BAL_W]) begin
                status_d = STAT_OVERFLOW;
              end else begin
                wa_en    = 1'b1;
                wa_bal   = dep_sum[BAL_W-1:0];
                bal_d    = dep_sum[BAL_W-1:0];
                status_d = STAT_OK;
              end
            end
            ST_TRANSFER: begin
              done_d = 1'b1;
              if (!lk_hit || (lk_idx == sess_idx_q)) begin
                status_d = STAT_BAD_TGT;
              end else if (amt_zero) begin
                status_d = STAT_ZERO_AMT;
              end else if (amt_insuff) begin
                status_d = STAT_INSUFF;
              end else if (tgt_sum[BAL_W]) begin
                status_d = STAT_OVERFLOW;
              end else begin
                wa_en    = 1'b1;
                wb_en    = 1'b1;
                bal_d    = wd_bal;
                status_d = STAT_OK;
              end
            end
            default: ;
          endcase
        end else if (timer_q == TMR_LAST) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          status_d = STAT_TIMEOUT;
        end
      end
    endcase
    // Idle timer only runs inside a session; any load or session entry restarts it.
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || load) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sess_idx_q <= '0;
      bal_q      <= '0;
      status_q   <= STAT_OK;
      done_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      sess_idx_q <= sess_idx_d;
      bal_q      <= bal_d;
      status_q   <= status_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
    end
  end

  assign state  = state_q;
  assign auth   = (state_q != ST_IDLE);
  assign bal    = bal_q;
  assign status = status_q;
  assign done   = done_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl
// Scoreboard bench for atm_session_ctrl: every load pushes its expected
// outcome; a monitor pops and compares one cycle after the load is sampled.
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int TIMEOUT_CYC = 1000;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [11:0] keypad;
  logic        load;
  logic        logout;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [3:0]  cfg_acc;
  logic [7:0]  cfg_pin;
  logic [7:0]  cfg_bal;
  logic [2:0]  state;
  logic        auth;
  logic [7:0]  bal;
  logic [2:0]  status;
  logic        done;
  logic [3:0]  locked;

  typedef struct {
    logic       done;
    logic [2:0] status;
    logic [7:0] bal;
    logic [2:0] state;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] held_status;
  logic [7:0] held_bal;

  atm_session_ctrl #(
    .NUM_ACC     (4),
    .ACC_W       (4),
    .PIN_W       (8),
    .BAL_W       (8),
    .MAX_TRIES   (3),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .IDX_W       (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .keypad  (keypad),
    .load    (load),
    .logout  (logout),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_acc (cfg_acc),
    .cfg_pin (cfg_pin),
    .cfg_bal (cfg_bal),
    .state   (state),
    .auth    (auth),
    .bal     (bal),
    .status  (status),
    .done    (done),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Drives one load at a falling edge and records the expected result.
  // exp_bal < 0 means the reported balance must stay as it was; status only
  // changes when a done pulse is expected.
  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] acc, input logic [7:0] val,
                               input bit lo, input bit exp_done, input logic [2:0] exp_status,
                               input int exp_bal, input logic [2:0] exp_state);
    exp_t e;
    @(negedge clk);
    cfg_we = 1'b0;
    mode   = m;
    keypad = {acc, val};
    load   = 1'b1;
    logout = lo;
    if (exp_done) held_status = exp_status;
    if (exp_bal >= 0) held_bal = exp_bal[7:0];
    e.done   = exp_done;
    e.status = held_status;
    e.bal    = held_bal;
    e.state  = exp_state;
    sb_q.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    load   = 1'b0;
    logout = 1'b0;
    cfg_we = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic programRecord(input logic [1:0] idx, input logic [3:0] acc, input logic [7:0] pin,
                               input logic [7:0] b);
    @(negedge clk);
    load    = 1'b0;
    logout  = 1'b0;
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_acc = acc;
    cfg_pin = pin;
    cfg_bal = b;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic doLogout(input string tag);
    @(negedge clk);
    load   = 1'b0;
    logout = 1'b1;
    @(negedge clk);
    logout = 1'b0;
    checkOutput({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    checkOutput({tag, "_auth"}, 32'(auth), 0);
    checkOutput({tag, "_nodone"}, 32'(done), 0);
  endtask

  // Monitor: compares DUT outputs one cycle after every sampled load.
  initial begin
    bit   sampled;
    exp_t e;
    forever begin
      @(posedge clk);
      sampled = load && rst_n;
      #1;
      if (sampled) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_done", 32'(done), 32'(e.done));
          checkOutput("sb_status", 32'(status), 32'(e.status));
          checkOutput("sb_bal", 32'(bal), 32'(e.bal));
          checkOutput("sb_state", 32'(state), 32'(e.state));
          checkOutput("sb_auth", 32'(auth), 32'(e.state != 3'd0));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0; mode = '0; keypad = '0; load = 1'b0; logout = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_acc = '0; cfg_pin = '0; cfg_bal = '0;
    held_status = STAT_OK;
    held_bal    = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_auth", 32'(auth), 0);
    checkOutput("rst_bal", 32'(bal), 0);
    checkOutput("rst_status", 32'(status), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    rst_n = 1'b1;

    // Basic login and balance query.
    programRecord(2'd0, 4'hA, 8'h11, 8'd50);
    programRecord(2'd1, 4'hB, 8'h22, 8'd175);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_BALANCE, 4'h0, 8'h00, 0, 1, STAT_OK, 50, ST_MENU);
    doLogout("logout1");

    // PIN retry lockout, then reprogramming clears it.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h99, 0, 1, STAT_BAD_PIN, -1, ST_IDLE);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h99, 0, 1, STAT_BAD_PIN, -1, ST_IDLE);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h99, 0, 1, STAT_BAD_PIN, -1, ST_IDLE);
    idleCycles(1);
    checkOutput("lock_set", 32'(locked), 32'h1);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_LOCKED, -1, ST_IDLE);
    programRecord(2'd0, 4'hA, 8'h11, 8'd50);
    checkOutput("lock_clr", 32'(locked), 0);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    doLogout("logout2");

    // Withdraw: insufficient, zero, exact balance (back-to-back loads).
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_WITHDRAW, 4'h0, 8'd0, 0, 0, 0, -1, ST_WITHDRAW);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd60, 0, 1, STAT_INSUFF, -1, ST_MENU);
    applyStimulus(MODE_WITHDRAW, 4'h0, 8'd0, 0, 0, 0, -1, ST_WITHDRAW);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd0, 0, 1, STAT_ZERO_AMT, -1, ST_MENU);
    applyStimulus(MODE_WITHDRAW, 4'h0, 8'd0, 0, 0, 0, -1, ST_WITHDRAW);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd50, 0, 1, STAT_OK, 0, ST_MENU);
    doLogout("logout3");

    // Deposit: overflow by one, then fill to the top of the range.
    applyStimulus(MODE_BALANCE, 4'hB, 8'h22, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_DEPOSIT, 4'h0, 8'd0, 0, 0, 0, -1, ST_DEPOSIT);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd81, 0, 1, STAT_OVERFLOW, -1, ST_MENU);
    applyStimulus(MODE_DEPOSIT, 4'h0, 8'd0, 0, 0, 0, -1, ST_DEPOSIT);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd80, 0, 1, STAT_OK, 255, ST_MENU);
    doLogout("logout4");

    // Transfer: absent target, self target, valid transfer to B.
    programRecord(2'd0, 4'hA, 8'h11, 8'd50);
    programRecord(2'd1, 4'hB, 8'h22, 8'd175);
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_TRANSFER, 4'h0, 8'd0, 0, 0, 0, -1, ST_TRANSFER);
    applyStimulus(MODE_BALANCE, 4'hC, 8'd20, 0, 1, STAT_BAD_TGT, -1, ST_MENU);
    applyStimulus(MODE_TRANSFER, 4'h0, 8'd0, 0, 0, 0, -1, ST_TRANSFER);
    applyStimulus(MODE_BALANCE, 4'hA, 8'd20, 0, 1, STAT_BAD_TGT, -1, ST_MENU);
    applyStimulus(MODE_TRANSFER, 4'h0, 8'd0, 0, 0, 0, -1, ST_TRANSFER);
    applyStimulus(MODE_BALANCE, 4'hB, 8'd20, 0, 1, STAT_OK, 30, ST_MENU);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd0, 0, 1, STAT_OK, 30, ST_MENU);
    doLogout("logout5");
    applyStimulus(MODE_BALANCE, 4'hB, 8'h22, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd0, 0, 1, STAT_OK, 195, ST_MENU);
    doLogout("logout6");

    // cfg_we and load together in IDLE: the write wins, the login is dropped.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 0, 0, -1, ST_IDLE);
    cfg_we  = 1'b1;
    cfg_idx = 2'd2;
    cfg_acc = 4'hC;
    cfg_pin = 8'h33;
    cfg_bal = 8'd10;
    idleCycles(1);
    applyStimulus(MODE_BALANCE, 4'hC, 8'h33, 0, 1, STAT_OK, -1, ST_MENU);
    doLogout("logout7");

    // Logout coincident with a balance load: no done, balance not reported.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_BALANCE, 4'h0, 8'd0, 1, 0, 0, -1, ST_IDLE);
    idleCycles(1);

    // Inactivity timeout.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    idleCycles(1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < TIMEOUT_CYC + 100) begin
      @(posedge clk);
      cnt++;
      #2;
      if (done) seen = 1'b1;
    end
    checkOutput("timeout_seen", 32'(seen), 1);
    checkOutput("timeout_cycles", 32'(cnt), 32'(TIMEOUT_CYC));
    checkOutput("timeout_status", 32'(status), 32'(STAT_TIMEOUT));
    checkOutput("timeout_state", 32'(state), 32'(ST_IDLE));
    checkOutput("timeout_auth", 32'(auth), 0);
    checkOutput("timeout_bal", 32'(bal), 195);
    @(posedge clk);
    #2;
    checkOutput("timeout_pulse", 32'(done), 0);
    held_status = STAT_TIMEOUT;

    // Reset asserted while in TRANSFER.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_OK, -1, ST_MENU);
    applyStimulus(MODE_TRANSFER, 4'h0, 8'd0, 0, 0, 0, -1, ST_TRANSFER);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_state", 32'(state), 0);
    checkOutput("midrst_auth", 32'(auth), 0);
    checkOutput("midrst_bal", 32'(bal), 0);
    checkOutput("midrst_status", 32'(status), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_locked", 32'(locked), 0);
    rst_n       = 1'b1;
    held_status = STAT_OK;
    held_bal    = '0;
    // Records are invalid after reset, so the old login must fail.
    applyStimulus(MODE_BALANCE, 4'hA, 8'h11, 0, 1, STAT_BAD_PIN, -1, ST_IDLE);
    idleCycles(2);
    checkOutput("sb_drained", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
